// File: rtl/tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tx_frame_arbiter
// Description : Frame-atomic round-robin arbiter sharing the MAC TX byte
//               stream between NUM_PORTS payload producers, with truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_frame_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int MAX_FRAME_LEN = 1500
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   req_valid,
    input  logic [8*NUM_PORTS-1:0] req_data,
    input  logic [NUM_PORTS-1:0]   req_eof,
    output logic [NUM_PORTS-1:0]   req_ready,
    input  logic                   mac_ready,
    output logic                   mac_valid,
    output logic [7:0]             mac_data,
    output logic                   mac_eof,
    output logic [NUM_PORTS-1:0]   grant,
    output logic                   truncated
);

    localparam int CW = $clog2(MAX_FRAME_LEN + 1);
    localparam int IW = $clog2(NUM_PORTS);
    localparam logic [CW-1:0] C_LAST_CNT = CW'(MAX_FRAME_LEN - 1);
    localparam logic [IW-1:0] C_LAST_IDX = IW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic [7:0]           port_bytes [NUM_PORTS];
    logic                 arb_found;
    logic [IW-1:0]        arb_idx;
    logic                 sel_valid;
    logic                 sel_eof;
    logic [7:0]           sel_data;
    logic                 at_limit;
    logic [IW-1:0]        next_ptr;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign port_bytes[i] = req_data[8*i +: 8];
    end

    assign sel_valid = req_valid[gidx_q];
    assign sel_eof   = req_eof[gidx_q];
    assign sel_data  = port_bytes[gidx_q];
    assign at_limit  = (count_q == C_LAST_CNT);
    assign next_ptr  = (gidx_q == C_LAST_IDX) ? '0 : gidx_q + IW'(1);
    assign grant     = grant_q;

    // Round-robin search starting at the pointer, wrapping past the top port.
    always_comb begin
        logic [IW:0] cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_PORTS)) begin
                cand = cand - (IW+1)'(NUM_PORTS);
            end
            if (!arb_found && req_valid[cand[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        req_ready = '0;
        mac_valid = 1'b0;
        mac_data  = 8'h00;
        mac_eof   = 1'b0;
        truncated = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << arb_idx;
                    gidx_d  = arb_idx;
                    count_d = '0;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                mac_valid         = sel_valid;
                mac_data          = sel_data;
                mac_eof           = sel_eof | at_limit;
                req_ready[gidx_q] = mac_ready;
                if (sel_valid && mac_ready) begin
                    count_d = count_q + CW'(1);
                    // A genuine eof landing on the limit is a normal end.
                    if (sel_eof) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = next_ptr;
                    end else if (at_limit) begin
                        truncated = 1'b1;
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                req_ready[gidx_q] = 1'b1;
                if (sel_valid && sel_eof) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_frame_arbiter
// Description : Directed bench for tx_frame_arbiter (default and 8-byte limit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_frame_arbiter;

    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   req_valid;
    logic [NP-1:0]   req_eof;
    logic [8*NP-1:0] req_data;
    logic            mac_ready;

    logic [NP-1:0]   a_ready, a_grant, b_ready, b_grant;
    logic            a_valid, a_eof, a_trunc, b_valid, b_eof, b_trunc;
    logic [7:0]      a_data, b_data;

    logic [NP-1:0]   mon_ready, mon_grant;
    logic            mon_valid, mon_eof, mon_trunc;
    logic [7:0]      mon_data;
    logic            sel_b;

    int              n_vec  = 0;
    int              n_miss = 0;
    logic [8:0]      src_mem [NP][32];
    int              src_len [NP];
    int              src_pos [NP];
    logic [8:0]      sink [64];
    logic [NP-1:0]   gnt_log [64];
    int              sink_n, cyc, trunc_n, trunc_cyc, rr_bad, mr_mode;

    always #4 clk = ~clk;

    tx_frame_arbiter #(.NUM_PORTS(NP), .MAX_FRAME_LEN(1500)) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_eof(req_eof), .req_ready(a_ready), .mac_ready(mac_ready),
        .mac_valid(a_valid), .mac_data(a_data), .mac_eof(a_eof),
        .grant(a_grant), .truncated(a_trunc)
    );

    tx_frame_arbiter #(.NUM_PORTS(NP), .MAX_FRAME_LEN(8)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_eof(req_eof), .req_ready(b_ready), .mac_ready(mac_ready),
        .mac_valid(b_valid), .mac_data(b_data), .mac_eof(b_eof),
        .grant(b_grant), .truncated(b_trunc)
    );

    always_comb begin
        mon_ready = sel_b ? b_ready : a_ready;
        mon_grant = sel_b ? b_grant : a_grant;
        mon_valid = sel_b ? b_valid : a_valid;
        mon_eof   = sel_b ? b_eof   : a_eof;
        mon_trunc = sel_b ? b_trunc : a_trunc;
        mon_data  = sel_b ? b_data  : a_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NP; i++) begin
            if (src_pos[i] < src_len[i]) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
                req_eof[i]        = src_mem[i][src_pos[i]][8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_eof[i]        = 1'b0;
            end
        end
        mac_ready = (mr_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    endtask

    // Appends an n-byte frame of incrementing bytes, eof on the last one.
    task automatic load_frame(input int p, input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            src_mem[p][src_len[p]] = {(k == n - 1), first + 8'(k)};
            src_len[p]++;
        end
    endtask

    task automatic clear_logs();
        cyc = 0; sink_n = 0; trunc_n = 0; trunc_cyc = -1; rr_bad = 0;
    endtask

    task automatic do_reset(input bit use_b, input int mode);
        @(posedge clk);
        #1;
        sel_b   = use_b;
        mr_mode = mode;
        reset   = 1'b1;
        for (int i = 0; i < NP; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        clear_logs();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Log this cycle's outputs, retire handshakes, then advance one clock.
    task automatic step();
        if (cyc < 64) gnt_log[cyc] = mon_grant;
        if (mon_trunc) begin
            trunc_n++;
            trunc_cyc = cyc;
        end
        if (mon_valid && mac_ready && sink_n < 64) begin
            sink[sink_n] = {mon_eof, mon_data};
            sink_n++;
        end
        if (mr_mode == 1 && mon_grant[1] && (mon_ready[1] !== mac_ready)) rr_bad++;
        for (int i = 0; i < NP; i++) begin
            if (req_valid[i] && mon_ready[i]) src_pos[i]++;
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic logic [63:0] sink_bytes(input int start, input int n);
        logic [63:0] r = '0;
        for (int k = start; k < start + n; k++) r = (r << 8) | 64'(sink[k][7:0]);
        return r;
    endfunction

    function automatic logic [63:0] sink_eofs(input int start, input int n);
        logic [63:0] r = '0;
        for (int k = start; k < start + n; k++) r = (r << 1) | 64'(sink[k][8]);
        return r;
    endfunction

    function automatic logic [63:0] gnt_pack(input int start, input int n);
        logic [63:0] r = '0;
        for (int k = start; k < start + n; k++) r = (r << 4) | 64'(gnt_log[k]);
        return r;
    endfunction

    initial begin
        logic [NP-1:0] gseq [16];
        int            gs_n;
        reset     = 1'b1;
        req_valid = '0;
        req_eof   = '0;
        req_data  = '0;
        mac_ready = 1'b0;
        sel_b     = 1'b0;
        mr_mode   = 0;

        // Single port, 5-byte frame.
        do_reset(1'b0, 0);
        load_frame(2, 8'h10, 5);
        drive_inputs();
        #1;
        check("rst_ready", 64'(mon_ready), 64'h0);
        check("rst_grant", 64'(mon_grant), 64'h0);
        check("rst_outs", {54'h0, mon_valid, mon_eof, mon_trunc, mon_data[6:0]}, 64'h0);
        run(8);
        check("t1_grant", gnt_pack(0, 7), 64'h0444440);
        check("t1_bytes", sink_bytes(0, 5), 64'h1011121314);
        check("t1_eofs", sink_eofs(0, 5), 64'b00001);
        check("t1_count", 64'(sink_n), 64'd5);

        // Two simultaneous 3-byte frames, no interleaving.
        do_reset(1'b0, 0);
        load_frame(0, 8'h20, 3);
        load_frame(1, 8'h30, 3);
        drive_inputs();
        #1;
        run(10);
        check("t2_grant", gnt_pack(0, 9), 64'h011102220);
        check("t2_bytes", sink_bytes(0, 6), 64'h202122303132);
        check("t2_eofs", sink_eofs(0, 6), 64'b001001);

        // Four ports, four 1-byte frames each.
        do_reset(1'b0, 0);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < NP; i++) load_frame(i, 8'h40 + 8'(i * 4 + j), 1);
        drive_inputs();
        #1;
        run(36);
        gs_n = 0;
        for (int k = 0; k < 36; k++) begin
            if (gnt_log[k] != '0 && gs_n < 16) begin
                gseq[gs_n] = gnt_log[k];
                gs_n++;
            end
        end
        check("t3_frames", 64'(gs_n), 64'd16);
        check("t3_bytes", 64'(sink_n), 64'd16);
        for (int k = 0; k < 16; k++) begin
            check("t3_order", 64'(gseq[k]), 64'(1 << (k % 4)));
            check("t3_data", 64'(sink[k]), 64'({1'b1, 8'h40 + 8'((k % 4) * 4 + k / 4)}));
        end

        // Port 1 under mac_ready back-pressure 1,0,0,...
        do_reset(1'b0, 1);
        load_frame(1, 8'hA0, 6);
        drive_inputs();
        #1;
        run(24);
        check("t4_bytes", sink_bytes(0, 6), 64'hA0A1A2A3A4A5);
        check("t4_eofs", sink_eofs(0, 6), 64'b000001);
        check("t4_count", 64'(sink_n), 64'd6);
        check("t4_ready_track", 64'(rr_bad), 64'd0);
        check("t4_grant_end", gnt_pack(18, 2), 64'h20);

        // 8-byte limit: 12-byte frame is truncated and drained.
        do_reset(1'b1, 0);
        load_frame(3, 8'h00, 12);
        drive_inputs();
        #1;
        run(16);
        check("t5_count", 64'(sink_n), 64'd8);
        check("t5_bytes", sink_bytes(0, 8), 64'h0001020304050607);
        check("t5_eofs", sink_eofs(0, 8), 64'b00000001);
        check("t5_trunc_n", 64'(trunc_n), 64'd1);
        check("t5_trunc_cyc", 64'(trunc_cyc), 64'd8);
        check("t5_drained", 64'(src_pos[3]), 64'd12);
        check("t5_grant_end", gnt_pack(12, 2), 64'h80);

        // Exactly 8 bytes with eof on the limit is a normal end.
        do_reset(1'b1, 0);
        load_frame(0, 8'h50, 8);
        drive_inputs();
        #1;
        run(12);
        check("t5b_bytes", sink_bytes(0, 8), 64'h5051525354555657);
        check("t5b_eofs", sink_eofs(0, 8), 64'b00000001);
        check("t5b_trunc_n", 64'(trunc_n), 64'd0);
        check("t5b_grant_end", gnt_pack(8, 2), 64'h10);

        // Reset on the 3rd byte of port 0's 10-byte frame.
        do_reset(1'b0, 0);
        load_frame(0, 8'h60, 10);
        drive_inputs();
        #1;
        run(3);
        check("t6_mid_data", 64'(mon_data), 64'h62);
        reset = 1'b1;
        step();
        check("t6_rst_grant", 64'(mon_grant), 64'h0);
        check("t6_rst_ready", 64'(mon_ready), 64'h0);
        check("t6_rst_outs", {55'h0, mon_valid, mon_eof, mon_data[6:0]}, 64'h0);
        check("t6_rst_data7", 64'(mon_data[7]), 64'h0);
        reset = 1'b0;
        for (int i = 0; i < NP; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        load_frame(1, 8'h71, 1);
        load_frame(0, 8'h70, 1);
        clear_logs();
        drive_inputs();
        #1;
        run(6);
        check("t6_first_grant", gnt_pack(0, 5), 64'h01020);
        check("t6_bytes", sink_bytes(0, 2), 64'h7071);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Shares the single TX payload byte stream of the Ethernet MAC (ready/valid/data/eof) between NUM_PORTS requesters.
- Frame-atomic round-robin: once a port is granted, the arbiter passes its bytes through until eof, then re-arbitrates.
- Enforces a maximum payload length; oversize frames are truncated toward the MAC and the remainder is drained from the requester.
- Sits between payload producers (e.g. command/response engines) and the MAC TX FIFO.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- MAX_FRAME_LEN, 1500, maximum payload bytes forwarded per frame (1..2047).

Ports:
- clk  input  1  system clock (125 MHz)
- reset  input  1  reset, synchronous, active-high
- req_valid  input  NUM_PORTS  per-port byte valid
- req_data  input  8*NUM_PORTS  per-port byte; port i on bits [8i+7:8i]
- req_eof  input  NUM_PORTS  per-port last-byte marker, qualified by req_valid
- req_ready  output  NUM_PORTS  per-port byte accepted when req_valid & req_ready
- mac_ready  input  1  MAC TX FIFO can accept a byte
- mac_valid  output  1  byte valid to MAC
- mac_data  output  8  byte to MAC
- mac_eof  output  1  last byte of frame to MAC
- grant  output  NUM_PORTS  one-hot current owner; all-zero when idle
- truncated  output  1  one-cycle pulse when a frame is cut at MAX_FRAME_LEN

Behaviour:
- Reset: state IDLE; grant=0; priority pointer=0 (port 0 highest); byte count=0; req_ready=0, mac_valid=0, mac_eof=0, mac_data=0, truncated=0. Reset mid-frame abandons the frame immediately with no eof emitted. Downstream cleanup of the partial frame is the MAC's concern.
- States: IDLE, PASS, DRAIN.
- IDLE:
  - Outputs all deasserted.
  - If any req_valid is set, select the first set port searching from pointer upward, with wrap-around.
  - Register the one-hot grant, clear the count, and go to PASS next cycle.
  - Arbitration costs exactly one idle cycle between frames.
- PASS (granted port g), combinational pass-through:
  - mac_valid = req_valid[g], mac_data = req_data[g], req_ready[g] = mac_ready; all other req_ready = 0.
  - mac_eof = req_eof[g] | (count == MAX_FRAME_LEN-1).
  - Transfer = mac_valid & mac_ready; count increments by 1 per transfer. Count width is clog2(MAX_FRAME_LEN+1), so it never wraps.
  - Transfer with req_eof[g]: go to IDLE, pointer = (g+1) mod NUM_PORTS, grant cleared next cycle.
  - Transfer at count == MAX_FRAME_LEN-1 without req_eof: pulse truncated, go to DRAIN. If req_eof coincides with the limit, this is a normal end: go to IDLE with no truncated pulse.
  - mac_ready low: hold everything. No byte lost or duplicated; req_valid deassertion mid-frame simply stalls.
- DRAIN (port g):
  - mac_valid = 0; req_ready[g] = 1.
  - Bytes are discarded until a req_eof[g] transfer, then go to IDLE and advance the pointer as in PASS.
- Grant is never changed mid-frame. Non-granted ports see req_ready = 0 and must hold their data.
- Simultaneous requests are resolved only by the pointer. A port re-requesting immediately after its eof has lowest priority.
- Single-byte frames (eof on the first byte) are legal: one PASS cycle plus one IDLE cycle.
- MAX_FRAME_LEN = 1: every byte carries mac_eof. Any non-eof first byte triggers truncated and DRAIN.

Test Plan:
- Port 2 alone sends 5 bytes 0x10..0x14, eof on 0x14, mac_ready=1 -> mac sees the same 5 bytes with mac_eof on 0x14; grant=0b0100 for 5 cycles after 1 arbitration cycle; then grant=0.
- Ports 0 and 1 both request at once, 3-byte frames each -> port 0 frame fully, 1 idle cycle, then port 1 frame; no interleaving.
- Ports 0..3 continuously request 1-byte frames for 16 frames -> grant order 0,1,2,3 repeating; each port gets exactly 4 frames.
- Port 1 sends 6 bytes while mac_ready toggles 1,0,0,1,... -> output byte sequence is identical; req_ready[1] tracks mac_ready; no duplicates.
- MAX_FRAME_LEN=8, port 3 sends 12 bytes 0x00..0x0B -> mac gets 0x00..0x07 with mac_eof on 0x07; truncated pulses once; 0x08..0x0B accepted with mac_valid=0; then IDLE.
- Assert reset on the 3rd byte of port 0's 10-byte frame -> next cycle grant=0 and all outputs 0. After reset, pending port 1 and port 0 requests -> port 0 granted first (pointer=0).
